// File: rtl/expr_vh_pkg.sv
// Shared constants for the vloghammer result capture stage: bus geometry,
// field table and FSM state encoding.
package expr_vh_pkg;

  localparam int unsigned Y_W        = 90;
  localparam int unsigned NUM_FIELDS = 18;
  localparam int unsigned SIG_W      = 32;

  // Field i occupies y[FIELD_MSB[i]:FIELD_LSB[i]]; y0 sits at the top of the bus.
  localparam int unsigned FIELD_MSB [NUM_FIELDS] = '{
    89, 85, 80, 74, 70, 65, 59, 55, 50, 44, 40, 35, 29, 25, 20, 14, 10, 5
  };
  localparam int unsigned FIELD_LSB [NUM_FIELDS] = '{
    86, 81, 75, 71, 66, 60, 56, 51, 45, 41, 36, 30, 26, 21, 15, 11, 6, 0
  };

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    FOLD0 = 3'd2,
    FOLD1 = 3'd3,
    FOLD2 = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/expr_misr_step.sv
// One MISR step: shift left, apply feedback polynomial on msb carry-out, absorb chunk.
module expr_misr_step
  import expr_vh_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY = 32'h04C11DB7
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic [SIG_W-1:0] chunk_i,
  output logic [SIG_W-1:0] sig_o
);

  logic [SIG_W-1:0] fb_c;

  assign fb_c  = sig_i[SIG_W-1] ? POLY : '0;
  assign sig_o = {sig_i[SIG_W-2:0], 1'b0} ^ fb_c ^ chunk_i;

endmodule

// File: rtl/expr_result_sig.sv
// Capture stage: accepts 90-bit result vectors, checks them field-wise against an
// expected vector, folds them into a MISR signature and keeps run statistics.
module expr_result_sig
  import expr_vh_pkg::*;
#(
  parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
  parameter logic [SIG_W-1:0] SEED  = 32'h00000000,
  parameter int unsigned      CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [Y_W-1:0]        in_y,
  input  logic [Y_W-1:0]        in_exp,
  input  logic                  in_cmp_en,
  input  logic                  in_last,
  output logic [SIG_W-1:0]      sig,
  output logic [CNT_W-1:0]      vec_count,
  output logic [CNT_W-1:0]      mism_count,
  output logic [NUM_FIELDS-1:0] field_mism,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic                  last_q, last_d;
  logic [SIG_W-1:0]      sig_q, sig_d;
  logic [CNT_W-1:0]      vec_q, vec_d;
  logic [CNT_W-1:0]      mism_q, mism_d;
  logic [NUM_FIELDS-1:0] field_q, field_d;

  logic [NUM_FIELDS-1:0] diff_c;
  logic [SIG_W-1:0]      chunk_c;
  logic [SIG_W-1:0]      misr_next_c;
  logic [CNT_W-1:0]      vec_inc_c, mism_inc_c;
  logic                  accept_c;

  // Per-field inequality, laid out from the package field table.
  for (genvar i = 0; i < NUM_FIELDS; i++) begin : g_cmp
    assign diff_c[i] = |(in_y[FIELD_MSB[i]:FIELD_LSB[i]] ^ in_exp[FIELD_MSB[i]:FIELD_LSB[i]]);
  end

  assign accept_c   = in_valid & in_ready;
  assign vec_inc_c  = (&vec_q)  ? vec_q  : vec_q  + CNT_W'(1);
  assign mism_inc_c = (&mism_q) ? mism_q : mism_q + CNT_W'(1);

  always_comb begin
    chunk_c = '0;
    case (state_q)
      FOLD0:   chunk_c = y_q[31:0];
      FOLD1:   chunk_c = y_q[63:32];
      FOLD2:   chunk_c = SIG_W'(y_q[89:64]);
      default: chunk_c = '0;
    endcase
  end

  expr_misr_step #(
    .POLY (POLY)
  ) u_misr (
    .sig_i   (sig_q),
    .chunk_i (chunk_c),
    .sig_o   (misr_next_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      y_q     <= '0;
      last_q  <= 1'b0;
      sig_q   <= SEED;
      vec_q   <= '0;
      mism_q  <= '0;
      field_q <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      last_q  <= last_d;
      sig_q   <= sig_d;
      vec_q   <= vec_d;
      mism_q  <= mism_d;
      field_q <= field_d;
    end
  end

  // Next state; start overrides everything, including an in-flight fold.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = WAIT;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        WAIT:    if (accept_c) state_d = FOLD0;
        FOLD0:   state_d = FOLD1;
        FOLD1:   state_d = FOLD2;
        FOLD2:   state_d = last_q ? DONE : WAIT;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: clear on start, capture/compare on accept, MISR step while folding.
  always_comb begin
    y_d     = y_q;
    last_d  = last_q;
    sig_d   = sig_q;
    vec_d   = vec_q;
    mism_d  = mism_q;
    field_d = field_q;
    if (start) begin
      sig_d   = SEED;
      vec_d   = '0;
      mism_d  = '0;
      field_d = '0;
    end else if (accept_c) begin
      y_d    = in_y;
      last_d = in_last;
      vec_d  = vec_inc_c;
      if (in_cmp_en) begin
        field_d = field_q | diff_c;
        if (|diff_c) mism_d = mism_inc_c;
      end
    end else if (busy) begin
      sig_d = misr_next_c;
    end
  end

  // State decode outputs.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      WAIT:                busy = 1'b0;
      FOLD0, FOLD1, FOLD2: busy = 1'b1;
      DONE:                done = 1'b1;
      default:             busy = 1'b0;
    endcase
    in_ready = (state_q == WAIT);
  end

  assign sig        = sig_q;
  assign vec_count  = vec_q;
  assign mism_count = mism_q;
  assign field_mism = field_q;

endmodule

// File: tb/tb_expr_result_sig.sv
// Directed + randomized bench for expr_result_sig, checked against a behavioural model;
// a second instance with 2-bit counters exercises counter saturation.
module tb_expr_result_sig;
  import expr_vh_pkg::*;

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] SEED = 32'h00000000;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_cmp_en, in_last;
  logic [89:0] in_y, in_exp;

  logic        in_ready, busy, done;
  logic [31:0] sig;
  logic [15:0] vec_count, mism_count;
  logic [17:0] field_mism;

  logic        in_ready_s, busy_s, done_s;
  logic [31:0] sig_s;
  logic [1:0]  vec_count_s, mism_count_s;
  logic [17:0] field_mism_s;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_sig;
  int          m_vec, m_mism;
  logic [17:0] m_field;

  expr_result_sig #(.POLY(POLY), .SEED(SEED), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_exp(in_exp), .in_cmp_en(in_cmp_en), .in_last(in_last),
    .sig(sig), .vec_count(vec_count), .mism_count(mism_count), .field_mism(field_mism),
    .busy(busy), .done(done)
  );

  expr_result_sig #(.POLY(POLY), .SEED(SEED), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_y(in_y), .in_exp(in_exp), .in_cmp_en(in_cmp_en), .in_last(in_last),
    .sig(sig_s), .vec_count(vec_count_s), .mism_count(mism_count_s), .field_mism(field_mism_s),
    .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] c);
    logic [31:0] r;
    r = s << 1;
    if (s[31]) r = r ^ POLY;
    return r ^ c;
  endfunction

  // Fields are 4,5,6 bits wide repeating, packed from bit 89 downward.
  function automatic logic [17:0] fdiff(input logic [89:0] y, input logic [89:0] e);
    logic [17:0] r;
    logic [89:0] d;
    int pos;
    int w;
    r = '0;
    d = y ^ e;
    pos = 89;
    for (int i = 0; i < 18; i++) begin
      w = 4 + (i % 3);
      for (int b = 0; b < w; b++) if (d[pos - b]) r[i] = 1'b1;
      pos = pos - w;
    end
    return r;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [89:0] rnd90();
    return 90'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sig"},     96'(sig),          96'(m_sig));
    chk({tag, ".vec"},     96'(vec_count),    96'(sat(m_vec, 65535)));
    chk({tag, ".mism"},    96'(mism_count),   96'(sat(m_mism, 65535)));
    chk({tag, ".field"},   96'(field_mism),   96'(m_field));
    chk({tag, ".sig_s"},   96'(sig_s),        96'(m_sig));
    chk({tag, ".vec_s"},   96'(vec_count_s),  96'(sat(m_vec, 3)));
    chk({tag, ".mism_s"},  96'(mism_count_s), 96'(sat(m_mism, 3)));
    chk({tag, ".field_s"}, 96'(field_mism_s), 96'(m_field));
  endtask

  task automatic model_clear();
    m_sig   = SEED;
    m_vec   = 0;
    m_mism  = 0;
    m_field = '0;
  endtask

  task automatic model_accept(input logic [89:0] y, input logic [89:0] e, input logic cmp);
    logic [17:0] fd;
    m_vec++;
    if (cmp) begin
      fd = fdiff(y, e);
      m_field = m_field | fd;
      if (fd != '0) m_mism++;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
  endtask

  task automatic send_vec(input logic [89:0] y, input logic [89:0] e, input logic cmp,
                          input logic last);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 96'(in_ready), 96'(1));
    in_valid = 1'b1; in_y = y; in_exp = e; in_cmp_en = cmp; in_last = last;
    step();
    in_valid = 1'b0; in_y = rnd90(); in_exp = rnd90(); in_cmp_en = ~cmp; in_last = ~last;
    model_accept(y, e, cmp);
    chk("busy_fold", 96'(busy), 96'(1));
    chk_all("accept");
    m_sig = misr(m_sig, y[31:0]);
    step();
    chk("sig_fold0", 96'(sig), 96'(m_sig));
    m_sig = misr(m_sig, y[63:32]);
    step();
    chk("sig_fold1", 96'(sig), 96'(m_sig));
    m_sig = misr(m_sig, {6'b0, y[89:64]});
    step();
    chk("sig_fold2", 96'(sig), 96'(m_sig));
    chk("done_after", 96'(done), 96'(last));
    chk("ready_after", 96'(in_ready), 96'(!last));
  endtask

  initial begin
    logic [89:0] y, e, mask;
    int          v0;
    logic        cmp;

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_cmp_en = 1'b0; in_last = 1'b0;
    in_y = '0; in_exp = '0;
    model_clear();
    step(); step();
    chk_all("reset");
    chk("reset.ready", 96'(in_ready), 96'(0));
    chk("reset.busy",  96'(busy),     96'(0));
    chk("reset.done",  96'(done),     96'(0));

    // reset dominates start
    start = 1'b1;
    step();
    start = 1'b0;
    chk("reset_over_start", 96'(in_ready), 96'(0));
    reset = 1'b0;

    // in_valid ignored in IDLE
    in_valid = 1'b1; in_y = rnd90();
    step(); step();
    in_valid = 1'b0;
    chk_all("idle_hold");
    chk("idle.ready", 96'(in_ready), 96'(0));

    do_start();
    chk("start.ready", 96'(in_ready), 96'(1));

    // single vector, last: sig 1,2,4
    send_vec(90'h1, 90'h1, 1'b1, 1'b1);
    chk("t1.sig", 96'(sig), 96'(4));
    chk("t1.vec", 96'(vec_count), 96'(1));

    // DONE holds and ignores in_valid
    in_valid = 1'b1; in_y = rnd90(); in_cmp_en = 1'b1;
    step(); step(); step();
    in_valid = 1'b0;
    chk_all("done_hold");
    chk("done_hold.done",  96'(done),     96'(1));
    chk("done_hold.ready", 96'(in_ready), 96'(0));

    do_start();
    chk_all("restart");
    chk("restart.ready", 96'(in_ready), 96'(1));

    // mismatch in bit 0 and bit 89 -> fields 17 and 0
    y = rnd90();
    mask = '0; mask[0] = 1'b1; mask[89] = 1'b1;
    send_vec(y, y ^ mask, 1'b1, 1'b0);
    chk("t2.field", 96'(field_mism), 96'(18'h20001));
    chk("t2.mism",  96'(mism_count), 96'(1));

    // compare disabled: mismatch not recorded, signature still folds
    y = rnd90();
    send_vec(y, ~y, 1'b0, 1'b0);

    // in_valid held 8 cycles: one accept per 4 cycles
    y = rnd90();
    v0 = m_vec;
    in_y = y; in_exp = y ^ 90'h3F; in_cmp_en = 1'b1; in_last = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t3.ready", 96'(in_ready), 96'((k % 4) == 0));
      if ((k % 4) == 0) begin
        model_accept(y, y ^ 90'h3F, 1'b1);
        m_sig = misr(misr(misr(m_sig, y[31:0]), y[63:32]), {6'b0, y[89:64]});
      end
      step();
    end
    in_valid = 1'b0;
    chk("t3.accepted", 96'(m_vec - v0), 96'(2));
    chk_all("t3");

    // start during FOLD1 discards the in-flight vector
    y = rnd90();
    in_valid = 1'b1; in_y = y; in_exp = ~y; in_cmp_en = 1'b1; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t4.busy", 96'(busy), 96'(1));
    do_start();
    chk_all("t4");
    chk("t4.ready", 96'(in_ready), 96'(1));
    step(); step(); step();
    chk_all("t4.settle");
    chk("t4.done", 96'(done), 96'(0));

    // randomized run; the 2-bit instance saturates along the way
    for (int i = 0; i < 40; i++) begin
      y = rnd90();
      mask = '0;
      if ($urandom_range(0, 1) == 1) mask[$urandom_range(0, 89)] = 1'b1;
      if ($urandom_range(0, 3) == 0) mask = mask | rnd90();
      cmp = 1'($urandom_range(0, 3) != 0);
      send_vec(y, y ^ mask, cmp, 1'(i == 39));
    end
    chk_all("rand_end");
    chk("rand_end.done", 96'(done), 96'(1));

    do_start();
    chk("final.ready", 96'(in_ready), 96'(1));
    chk_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
